// File: rtl/onehot_serializer8.sv
`default_nettype none
// ============================================================================
// Module   : onehot_serializer8
// Purpose  : Splits an 8-bit request word into one-hot beats, lowest bit first,
//            for the downstream 8x3 encoder. Optional macro:
//            SERIALIZER_ZERO_FLAG_EN (all-zero word emits one flagged beat).
// Revision : 1.0 - initial release
// ============================================================================
module onehot_serializer8 #(
    parameter int WIDTH = 8,
    parameter int IW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_onehot,
    output logic [IW-1:0]    out_idx,
    output logic             out_last,
`ifdef SERIALIZER_ZERO_FLAG_EN
    output logic             out_zero,
`endif
    output logic             busy
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SERVE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_pending;
    logic [WIDTH-1:0]   w_pending_nxt;
    logic [WIDTH-1:0]   w_lowbit;
    logic [IW-1:0]      w_idx;
    logic               w_single;
    logic               w_last;
    logic               w_in_ready;
    logic               w_enter_serve;

    // Two's-complement trick isolates the lowest set bit.
    assign w_lowbit = r_pending & (~r_pending + WIDTH'(1));
    assign w_single = (r_pending != '0) &&
                      ((r_pending & (r_pending - WIDTH'(1))) == '0);

`ifdef SERIALIZER_ZERO_FLAG_EN
    // An empty pending word in SERVE is the single flagged zero beat.
    assign w_last        = w_single || (r_pending == '0);
    assign w_enter_serve = 1'b1;
`else
    assign w_last        = w_single;
    assign w_enter_serve = (in_req != '0);
`endif

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_lowbit[i]) begin
                w_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_in_ready    = 1'b0;
        out_valid     = 1'b0;
        out_onehot    = '0;
        out_idx       = '0;
        out_last      = 1'b0;
        busy          = 1'b0;
`ifdef SERIALIZER_ZERO_FLAG_EN
        out_zero      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
            end
            S_SERVE: begin
                out_valid  = 1'b1;
                busy       = 1'b1;
                out_onehot = w_lowbit;
                out_idx    = w_idx;
                out_last   = w_last;
`ifdef SERIALIZER_ZERO_FLAG_EN
                out_zero   = (r_pending == '0);
`endif
                if (out_ready) begin
                    w_pending_nxt = r_pending & ~w_lowbit;
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                        // Last beat leaving frees the slot for a new word now.
                        w_in_ready  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (in_valid && w_in_ready) begin
            w_pending_nxt = in_req;
            w_state_nxt   = w_enter_serve ? S_SERVE : S_IDLE;
        end
    end

    assign in_ready = w_in_ready;

endmodule
`default_nettype wire
